dio24_reset_seq: RTL

Single-clock, parametrised reset sequencer that extends the dio24 reset scheme to NUM_SRC debounced reset sources and NUM_OUT staged reset outputs. Outputs assert outer-to-inner and release inner-to-outer with a fixed spacing, and a minimum hold time is enforced. The block latches a sticky cause word and counts reset events for diagnostics. It sits at the top of the dio24 datapath, and its inner channels drive FIFO and DMA resets.

---
 rtl/dio24_reset_pkg.sv | 19 +
 rtl/dio24_reset_filter.sv | 44 ++++
 rtl/dio24_reset_seq.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/dio24_reset_pkg.sv
// Shared state encodings and width helper for the dio24 reset sequencer.
package dio24_reset_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLD    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  // Bits needed to represent values 0..value-1 (minimum 1).
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned width;
    width = 1;
    while ((64'(1) << width) < 64'(value)) width = width + 1;
    return width;
  endfunction

endpackage

// File: rtl/dio24_reset_filter.sv
// Per-source debounce: the output follows the input only after it has
// differed for FILTER consecutive edges; rise pulses for one cycle on 0->1.
module dio24_reset_filter
  import dio24_reset_pkg::*;
#(
  parameter int unsigned FILTER = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic out,
  output logic rise
);

  localparam int unsigned           CNT_W    = clogb2(FILTER + 1);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(FILTER - 1);

  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             flip;

  assign differ = (in != out);
  assign flip   = differ && (cnt == CNT_LAST);

  // Count consecutive disagreeing edges; any agreement restarts the count.
  always_ff @(posedge clock) begin
    if (reset) begin
      out  <= 1'b0;
      rise <= 1'b0;
      cnt  <= '0;
    end else begin
      rise <= flip && in;
      if (flip) begin
        out <= in;
        cnt <= '0;
      end else if (differ) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/dio24_reset_seq.sv
// Staged reset sequencer: debounced request sources drive outer-to-inner
// assertion, a minimum hold, and inner-to-outer release of NUM_OUT resets.
module dio24_reset_seq
  import dio24_reset_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 3,
  parameter int unsigned NUM_OUT    = 3,
  parameter int unsigned FILTER     = 2,
  parameter int unsigned STEP_DELAY = 4,
  parameter int unsigned MIN_CYCLES = 8,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_SRC-1:0]   src_req,
  input  logic                 cause_clear,
  output logic [NUM_OUT-1:0]   out_reset,
  output logic                 ready,
  output logic                 busy,
  output logic [NUM_SRC:0]     cause,
  output logic [CNT_WIDTH-1:0] reset_events
);

  localparam int unsigned        STEP_W    = clogb2(STEP_DELAY + 1);
  localparam int unsigned        MIN_W     = clogb2(MIN_CYCLES + 1);
  localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(STEP_DELAY - 1);
  localparam logic [MIN_W-1:0]   MIN_SAT   = MIN_W'(MIN_CYCLES);

  state_t               state;
  state_t               state_d;
  logic [NUM_SRC-1:0]   filt;
  logic [NUM_SRC-1:0]   rise;
  logic                 any_req;
  logic                 any_rise;
  logic                 step_done;
  logic                 min_met;
  logic                 all_on;
  logic [NUM_OUT-1:0]   grow;
  logic [NUM_OUT-1:0]   shrink;
  logic [NUM_OUT-1:0]   out_reset_d;
  logic [STEP_W-1:0]    step_cnt;
  logic [STEP_W-1:0]    step_cnt_d;
  logic [MIN_W-1:0]     min_cnt;
  logic [MIN_W-1:0]     min_cnt_d;
  logic [NUM_SRC:0]     cause_d;
  logic [CNT_WIDTH-1:0] events_d;
  logic                 ready_d;

  // One debounce filter per request source.
  for (genvar k = 0; k < NUM_SRC; k++) begin : g_filt
    dio24_reset_filter #(
      .FILTER (FILTER)
    ) u_filt (
      .clock (clock),
      .reset (reset),
      .in    (src_req[k]),
      .out   (filt[k]),
      .rise  (rise[k])
    );
  end

  // Asserted channels always form a contiguous run from channel 0, so one
  // step outward/inward is a shift of that run.
  assign any_req   = |filt;
  assign any_rise  = |rise;
  assign step_done = (step_cnt == STEP_LAST);
  assign min_met   = (min_cnt >= MIN_SAT);
  assign all_on    = &out_reset;
  assign grow      = NUM_OUT'({out_reset, 1'b1});
  assign shrink    = out_reset >> 1;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= ST_HOLD;
    else       state <= state_d;
  end

  // Next-state decision.
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:    if (any_req) state_d = ST_ASSERT;
      ST_ASSERT:  if (step_done && all_on) state_d = ST_HOLD;
      ST_HOLD: begin
        if (min_met && !any_req) state_d = (shrink == '0) ? ST_IDLE : ST_RELEASE;
      end
      ST_RELEASE: begin
        if (any_req)                        state_d = ST_ASSERT;
        else if (step_done && shrink == '0) state_d = ST_IDLE;
      end
      default:    state_d = ST_HOLD;
    endcase
  end

  // Next values of the staged outputs, step/min counters and diagnostics.
  always_comb begin
    out_reset_d = out_reset;
    step_cnt_d  = step_cnt;
    min_cnt_d   = min_cnt;
    events_d    = reset_events;
    case (state)
      ST_IDLE: begin
        out_reset_d = '0;
        step_cnt_d  = '0;
        if (any_req) begin
          out_reset_d = grow;
          if (reset_events != {CNT_WIDTH{1'b1}}) events_d = reset_events + CNT_WIDTH'(1);
        end
      end
      ST_ASSERT: begin
        if (step_done) begin
          step_cnt_d = '0;
          if (all_on) min_cnt_d = '0;
          else        out_reset_d = grow;
        end else begin
          step_cnt_d = step_cnt + STEP_W'(1);
        end
      end
      ST_HOLD: begin
        step_cnt_d = '0;
        if (any_rise)                min_cnt_d   = '0;
        else if (min_met && !any_req) out_reset_d = shrink;
        else if (!min_met)           min_cnt_d   = min_cnt + MIN_W'(1);
      end
      ST_RELEASE: begin
        if (any_req) begin
          out_reset_d = grow;
          step_cnt_d  = '0;
        end else if (step_done) begin
          out_reset_d = shrink;
          step_cnt_d  = '0;
        end else begin
          step_cnt_d = step_cnt + STEP_W'(1);
        end
      end
      default: out_reset_d = '1;
    endcase
    cause_d = (cause & {(NUM_SRC + 1){~cause_clear}}) | {1'b0, rise};
    ready_d = (state_d == ST_IDLE);
  end

  // Output and counter registers; reset forces the safe all-asserted HOLD.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_reset    <= '1;
      step_cnt     <= '0;
      min_cnt      <= '0;
      ready        <= 1'b0;
      busy         <= 1'b1;
      cause        <= {1'b1, {NUM_SRC{1'b0}}};
      reset_events <= '0;
    end else begin
      out_reset    <= out_reset_d;
      step_cnt     <= step_cnt_d;
      min_cnt      <= min_cnt_d;
      ready        <= ready_d;
      busy         <= ~ready_d;
      cause        <= cause_d;
      reset_events <= events_d;
    end
  end

endmodule
